// File: rtl/mem_wb_if.sv
// Signal bundle between execute, the memory/writeback stage, data memory and the register file.
interface mem_wb_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic [31:0] in_result;
   logic [31:0] in_store_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        w_en;
   logic [4:0]  w_sel;
   logic [31:0] w_data;
   logic        fault;
   logic [1:0]  fault_cause;

   modport slave (
      input  in_valid, in_kind, in_funct3, in_rd, in_result, in_store_data, dmem_ack, dmem_rdata,
      output in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, w_en, w_sel, w_data,
             fault, fault_cause
   );

   modport master (
      output in_valid, in_kind, in_funct3, in_rd, in_result, in_store_data, dmem_ack, dmem_rdata,
      input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, w_en, w_sel, w_data,
             fault, fault_cause
   );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: runs loads/stores on a req/ack data bus with timeout,
// aligns load data and drives the register-file write port.
module mem_wb_stage #(
   parameter int unsigned DMEM_TIMEOUT = 255
) (
   input  logic    clk,
   input  logic    rst,
   mem_wb_if.slave bus
);
   localparam logic [1:0] KIND_ALU   = 2'b00;
   localparam logic [1:0] KIND_LOAD  = 2'b01;
   localparam logic [1:0] KIND_STORE = 2'b10;
   localparam logic [7:0] TIMEOUT_LIM = 8'(DMEM_TIMEOUT);

   typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rd_q, rd_d;
   logic        w_en_q, w_en_d;
   logic [4:0]  w_sel_q, w_sel_d;
   logic [31:0] w_data_q, w_data_d;
   logic        fault_q, fault_d;
   logic [1:0]  fault_cause_q, fault_cause_d;

   logic        xfer, is_mem_op, legal, mem_start, mem_ack, mem_timeout;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc, load_val;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Access decode of the operation currently offered by execute.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      legal      = 1'b0;
      be_calc    = 4'b0000;
      wdata_calc = '0;
      case (bus.in_funct3[1:0])
         2'b00: begin
            legal      = 1'b1;
            be_calc    = 4'b0001 << bus.in_result[1:0];
            wdata_calc = {4{bus.in_store_data[7:0]}};
         end
         2'b01: begin
            legal      = ~bus.in_result[0];
            be_calc    = bus.in_result[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{bus.in_store_data[15:0]}};
         end
         2'b10: begin
            legal      = (bus.in_result[1:0] == 2'b00);
            be_calc    = 4'b1111;
            wdata_calc = bus.in_store_data;
         end
         default: legal = 1'b0;
      endcase
      // Unsigned variants exist only for byte/half loads.
      if (bus.in_funct3[2] && (bus.in_kind == KIND_STORE || bus.in_funct3[1])) legal = 1'b0;
   end

   always_comb begin
      byte_v = bus.dmem_rdata[{off_q, 3'b000} +: 8];
      half_v = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   load_val = {{24{~funct3_q[2] & byte_v[7]}}, byte_v};
         2'b01:   load_val = {{16{~funct3_q[2] & half_v[15]}}, half_v};
         default: load_val = bus.dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      xfer        = bus.in_valid && (state_q == IDLE);
      is_mem_op   = (bus.in_kind == KIND_LOAD) || (bus.in_kind == KIND_STORE);
      mem_start   = xfer && is_mem_op && legal;
      mem_ack     = (state_q == MEM) && bus.dmem_ack;
      mem_timeout = (state_q == MEM) && !bus.dmem_ack && (cnt_q + 8'd1 == TIMEOUT_LIM);
      state_d     = state_q;
      case (state_q)
         IDLE: if (mem_start) state_d = MEM;
         MEM:  if (mem_ack || mem_timeout) state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d         = cnt_q;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      be_d          = be_q;
      wdata_d       = wdata_q;
      off_d         = off_q;
      funct3_d      = funct3_q;
      rd_d          = rd_q;
      w_en_d        = 1'b0;
      w_sel_d       = w_sel_q;
      w_data_d      = w_data_q;
      fault_d       = 1'b0;
      fault_cause_d = fault_cause_q;

      if (xfer && bus.in_kind == KIND_ALU && bus.in_rd != 5'd0) begin
         w_en_d   = 1'b1;
         w_sel_d  = bus.in_rd;
         w_data_d = bus.in_result;
      end else if (xfer && is_mem_op && !legal) begin
         fault_d       = 1'b1;
         fault_cause_d = 2'b01;
      end else if (mem_start) begin
         cnt_d    = 8'd0;
         req_d    = 1'b1;
         we_d     = (bus.in_kind == KIND_STORE);
         addr_d   = {bus.in_result[31:2], 2'b00};
         be_d     = be_calc;
         wdata_d  = (bus.in_kind == KIND_STORE) ? wdata_calc : '0;
         off_d    = bus.in_result[1:0];
         funct3_d = bus.in_funct3;
         rd_d     = bus.in_rd;
      end

      if (mem_ack) begin
         req_d = 1'b0;
         if (!we_q && rd_q != 5'd0) begin
            w_en_d   = 1'b1;
            w_sel_d  = rd_q;
            w_data_d = load_val;
         end
      end else if (mem_timeout) begin
         req_d         = 1'b0;
         fault_d       = 1'b1;
         fault_cause_d = 2'b10;
      end else if (state_q == MEM) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q         <= '0;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         be_q          <= '0;
         wdata_q       <= '0;
         off_q         <= '0;
         funct3_q      <= '0;
         rd_q          <= '0;
         w_en_q        <= 1'b0;
         w_sel_q       <= '0;
         w_data_q      <= '0;
         fault_q       <= 1'b0;
         fault_cause_q <= '0;
      end else begin
         cnt_q         <= cnt_d;
         req_q         <= req_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         be_q          <= be_d;
         wdata_q       <= wdata_d;
         off_q         <= off_d;
         funct3_q      <= funct3_d;
         rd_q          <= rd_d;
         w_en_q        <= w_en_d;
         w_sel_q       <= w_sel_d;
         w_data_q      <= w_data_d;
         fault_q       <= fault_d;
         fault_cause_q <= fault_cause_d;
      end
   end

   always_comb begin
      bus.in_ready    = (state_q == IDLE);
      bus.dmem_req    = req_q;
      bus.dmem_we     = we_q;
      bus.dmem_addr   = addr_q;
      bus.dmem_be     = be_q;
      bus.dmem_wdata  = wdata_q;
      bus.w_en        = w_en_q;
      bus.w_sel       = w_sel_q;
      bus.w_data      = w_data_q;
      bus.fault       = fault_q;
      bus.fault_cause = fault_cause_q;
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus random operations against
// an arithmetic reference model of alignment, lane selection and load extension.
module tb_mem_wb_stage;
   localparam int TMO = 4;
   localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_BUBBLE = 2'd3;

   logic clk, rst;
   mem_wb_if bus ();

   mem_wb_stage #(.DMEM_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [4:0]  exp_w_sel;
   logic [31:0] exp_w_data;
   logic [1:0]  exp_cause;

   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit legal_op(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] addr);
      int s = size_of(f3);
      if (kind == K_STORE && f3 > 3'd2) return 1'b0;
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
      return (addr % s) == 0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
      int s = size_of(f3);
      return 4'(((1 << s) - 1) << (addr % 4));
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] data);
      int s = size_of(f3);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = data[8*(i % s) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
      int s = size_of(f3);
      longint v = (longint'(rdata) >> (8 * (addr % 4))) & ((longint'(1) << (8 * s)) - 1);
      if (f3 == 3'd0 && v >= 128)   v -= 256;
      if (f3 == 3'd1 && v >= 32768) v -= 65536;
      return 32'(v);
   endfunction

   function automatic logic [111:0] out_vec();
      return {bus.in_ready, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata,
              bus.w_en, bus.w_sel, bus.w_data, bus.fault, bus.fault_cause};
   endfunction

   // Issues one operation at the current negedge and follows it to completion.
   // ack_at = MEM cycle (1..TMO) in which ack is returned, 0 = never.
   task automatic do_op(input logic [1:0] kind, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] sdata, input int ack_at,
                        input logic [31:0] rdata);
      bit is_mem, ok, acked, wr;
      logic [38:0] got_bus, exp_bus;
      is_mem = (kind == K_LOAD) || (kind == K_STORE);
      ok     = legal_op(kind, f3, res);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_before_op: got %b, expected 1", bus.in_ready);
      end
      bus.in_valid = 1'b1; bus.in_kind = kind; bus.in_funct3 = f3; bus.in_rd = rd;
      bus.in_result = res; bus.in_store_data = sdata;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_kind = 2'($urandom); bus.in_funct3 = 3'($urandom);
      bus.in_rd = 5'($urandom); bus.in_result = $urandom; bus.in_store_data = $urandom;
      if (!is_mem) begin
         wr = (kind == K_ALU) && (rd != 5'd0);
         if (wr) begin exp_w_sel = rd; exp_w_data = res; end
         n_checks++;
         if ({bus.w_en, bus.in_ready, bus.dmem_req, bus.fault} !== {wr, 3'b100}) begin
            n_fail++; $display("FAIL alu_or_bubble: got w_en/ready/req/fault=%b%b%b%b, expected %b100",
                               bus.w_en, bus.in_ready, bus.dmem_req, bus.fault, wr);
         end
      end else if (!ok) begin
         exp_cause = 2'b01;
         n_checks++;
         if ({bus.fault, bus.dmem_req, bus.w_en, bus.in_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL misalign_pulse: got fault/req/w_en/ready=%b%b%b%b, expected 1001",
                               bus.fault, bus.dmem_req, bus.w_en, bus.in_ready);
         end
      end else begin
         exp_bus = {1'b1, kind == K_STORE, 1'b0, exp_be(f3, res), res & 32'hFFFF_FFFC};
         acked = 1'b0;
         for (int c = 1; c <= TMO; c++) begin
            got_bus = {bus.dmem_req, bus.dmem_we, bus.in_ready, bus.dmem_be, bus.dmem_addr};
            n_checks++;
            if (got_bus !== exp_bus) begin
               n_fail++; $display("FAIL mem_bus cycle %0d: got %h, expected %h", c, got_bus, exp_bus);
            end
            if (kind == K_STORE) begin
               n_checks++;
               if (bus.dmem_wdata !== exp_wdata(f3, sdata)) begin
                  n_fail++; $display("FAIL store_wdata: got %h, expected %h", bus.dmem_wdata, exp_wdata(f3, sdata));
               end
            end
            n_checks++;
            if ({bus.w_en, bus.fault} !== 2'b00) begin
               n_fail++; $display("FAIL mem_quiet cycle %0d: got w_en/fault=%b%b, expected 00", c, bus.w_en, bus.fault);
            end
            if (c == ack_at) begin
               bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata; acked = 1'b1;
            end else begin
               bus.dmem_rdata = $urandom;
            end
            @(negedge clk);
            bus.dmem_ack = 1'b0;
            if (acked) break;
         end
         n_checks++;
         if ({bus.dmem_req, bus.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL mem_exit: got req/ready=%b%b, expected 01", bus.dmem_req, bus.in_ready);
         end
         if (acked) begin
            wr = (kind == K_LOAD) && (rd != 5'd0);
            if (wr) begin exp_w_sel = rd; exp_w_data = exp_load(f3, res, rdata); end
            n_checks++;
            if ({bus.w_en, bus.fault} !== {wr, 1'b0}) begin
               n_fail++; $display("FAIL mem_done: got w_en/fault=%b%b, expected %b0", bus.w_en, bus.fault, wr);
            end
         end else begin
            exp_cause = 2'b10;
            n_checks++;
            if ({bus.w_en, bus.fault} !== 2'b01) begin
               n_fail++; $display("FAIL timeout_pulse: got w_en/fault=%b%b, expected 01", bus.w_en, bus.fault);
            end
         end
      end
      n_checks++;
      if ({bus.w_sel, bus.w_data, bus.fault_cause} !== {exp_w_sel, exp_w_data, exp_cause}) begin
         n_fail++; $display("FAIL wb_state: got sel=%0d data=%h cause=%b, expected sel=%0d data=%h cause=%b",
                            bus.w_sel, bus.w_data, bus.fault_cause, exp_w_sel, exp_w_data, exp_cause);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_vec() !== {1'b1, 111'd0}) begin
         n_fail++; $display("FAIL reset_outputs: got %h, expected %h", out_vec(), {1'b1, 111'd0});
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_vec() !== {1'b1, 111'd0}) begin
         n_fail++; $display("FAIL post_reset_idle: got %h, expected %h", out_vec(), {1'b1, 111'd0});
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         bus.in_valid = 1'b1; bus.in_kind = K_ALU; bus.in_funct3 = 3'd0;
         bus.in_rd = 5'(i); bus.in_result = 32'(32'h11 * i);
         @(negedge clk);
         n_checks++;
         if ({bus.in_ready, bus.w_en, bus.w_sel, bus.w_data} !== {2'b11, 5'(i), 32'(32'h11 * i)}) begin
            n_fail++; $display("FAIL b2b_alu %0d: got ready=%b w_en=%b sel=%0d data=%h, expected 1 1 %0d %h",
                               i, bus.in_ready, bus.w_en, bus.w_sel, bus.w_data, i, 32'h11 * i);
         end
      end
      bus.in_valid = 1'b0;
      exp_w_sel = 5'd3; exp_w_data = 32'h33;
      @(negedge clk);
      n_checks++;
      if ({bus.w_en, bus.w_sel, bus.w_data} !== {1'b0, exp_w_sel, exp_w_data}) begin
         n_fail++; $display("FAIL b2b_hold: got w_en=%b sel=%0d data=%h, expected 0 3 00000033",
                            bus.w_en, bus.w_sel, bus.w_data);
      end
   endtask

   task automatic test_load_extend();
      do_op(K_LOAD, 3'b000, 5'd7, 32'h1003, 32'h0, 4, 32'h80FF_0000);
      do_op(K_LOAD, 3'b100, 5'd8, 32'h1003, 32'h0, 4, 32'h80FF_0000);
      do_op(K_LOAD, 3'b001, 5'd9, 32'h1002, 32'h0, 1, 32'h8001_7FFF);
      do_op(K_LOAD, 3'b101, 5'd10, 32'h1000, 32'h0, 2, 32'h1234_F00D);
   endtask

   task automatic test_store_misalign();
      do_op(K_STORE, 3'b001, 5'd3, 32'h2002, 32'h1234_ABCD, 2, 32'h0);
      do_op(K_LOAD, 3'b010, 5'd4, 32'h2002, 32'h0, 1, 32'h0);
      do_op(K_STORE, 3'b000, 5'd0, 32'h2001, 32'hAAAA_AA5A, 1, 32'h0);
      do_op(K_LOAD, 3'b111, 5'd6, 32'h2000, 32'h0, 1, 32'h0);
   endtask

   task automatic test_timeout();
      do_op(K_LOAD, 3'b010, 5'd5, 32'h3000, 32'h0, 0, 32'h0);
      do_op(K_LOAD, 3'b010, 5'd5, 32'h3004, 32'h0, TMO, 32'hCAFE_BABE);
   endtask

   task automatic test_x0_stray();
      do_op(K_LOAD, 3'b010, 5'd0, 32'h4000, 32'h0, 2, 32'hDEAD_BEEF);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = $urandom;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      n_checks++;
      if ({bus.in_ready, bus.dmem_req, bus.w_en, bus.fault, bus.w_sel, bus.w_data, bus.fault_cause} !==
          {4'b1000, exp_w_sel, exp_w_data, exp_cause}) begin
         n_fail++; $display("FAIL stray_ack: got ready/req/w_en/fault=%b%b%b%b sel=%0d data=%h",
                            bus.in_ready, bus.dmem_req, bus.w_en, bus.fault, bus.w_sel, bus.w_data);
      end
   endtask

   task automatic test_reset_mid_mem();
      bus.in_valid = 1'b1; bus.in_kind = K_LOAD; bus.in_funct3 = 3'b010;
      bus.in_rd = 5'd9; bus.in_result = 32'h5000;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.dmem_req !== 1'b1) begin
         n_fail++; $display("FAIL mid_mem_req: got %b, expected 1", bus.dmem_req);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_vec() !== {1'b1, 111'd0}) begin
         n_fail++; $display("FAIL async_reset: got %h, expected %h", out_vec(), {1'b1, 111'd0});
      end
      @(negedge clk);
      rst = 1'b0;
      exp_w_sel = '0; exp_w_data = '0; exp_cause = '0;
      @(negedge clk);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h7777_7777;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      n_checks++;
      if (out_vec() !== {1'b1, 111'd0}) begin
         n_fail++; $display("FAIL late_ack_ignored: got %h, expected %h", out_vec(), {1'b1, 111'd0});
      end
      do_op(K_ALU, 3'd0, 5'd4, 32'h0BAD_F00D, 32'h0, 0, 32'h0);
   endtask

   task automatic test_random();
      logic [2:0] f3;
      logic [31:0] addr;
      for (int i = 0; i < 80; i++) begin
         f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
         if ($urandom_range(0, 4) == 0) f3 = 3'd4 + 3'($urandom_range(0, 1));
         addr = $urandom;
         if ($urandom_range(0, 2) != 0) addr[1:0] = (f3[1:0] == 2'd0) ? addr[1:0] : {addr[1] & ~f3[1], 1'b0};
         do_op(2'($urandom), f3, 5'($urandom), addr, $urandom, $urandom_range(0, TMO), $urandom);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_funct3 = '0; bus.in_rd = '0;
      bus.in_result = '0; bus.in_store_data = '0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
      exp_w_sel = '0; exp_w_data = '0; exp_cause = '0;
      test_reset();
      test_back_to_back();
      test_load_extend();
      test_store_misalign();
      test_timeout();
      test_x0_stray();
      do_op(K_BUBBLE, 3'd2, 5'd12, 32'h1234_5678, 32'h0, 0, 32'h0);
      test_reset_mid_mem();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage of the RISC-V core. It sits between execute and the register file. It accepts one execute result per handshake and runs loads/stores on the data-memory bus with a req/ack handshake. It aligns load data with sign/zero extension and drives the register-file write port (`w_en`/`w_sel`/`w_data`).

## Interface
Parameters:
- `DMEM_TIMEOUT`, default 255: cycles to wait for `dmem_ack` before aborting an access. Legal range is 1–255.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: execute presents an operation.
- `in_ready` out 1: stage can accept an operation; equals `state==IDLE`.
- `in_kind` in 2: operation kind. `00` = ALU writeback, `01` = load, `10` = store, `11` = bubble (accepted, no effect).
- `in_funct3` in 3: access size. LB `000`, LH `001`, LW `010`, LBU `100`, LHU `101`; SB `000`, SH `001`, SW `010`.
- `in_rd` in 5: destination register.
- `in_result` in 32: ALU result, or effective address for a load/store.
- `in_store_data` in 32: rs2 value for stores.
- `dmem_req` out 1: memory request. Held high until ack or timeout.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: one-cycle completion pulse.
- `dmem_rdata` in 32: read word, valid when `dmem_ack` is high.
- `w_en` out 1: register-file write strobe, one cycle.
- `w_sel` out 5: register-file write index.
- `w_data` out 32: register-file write data.
- `fault` out 1: one-cycle fault pulse.
- `fault_cause` out 2: `01` = misaligned/illegal funct3, `10` = timeout. Holds its value until the next fault.

## Operation
- States: IDLE, MEM.
- A transfer occurs when `in_valid && in_ready`. Inputs are sampled only on a transfer.
- ALU (`00`): the state stays IDLE. The next cycle has `w_en=1`, `w_sel=in_rd`, `w_data=in_result`.
- Bubble (`11`): no outputs change.
- Load/store, legal and aligned: the state goes IDLE→MEM. `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are registered and stay stable for the whole of MEM.
- Alignment rules:
  - Byte: always legal.
  - Half: requires `addr[0]==0`.
  - Word: requires `addr[1:0]==0`.
  - Any funct3 not listed in the interface is illegal.
  - A fault stays IDLE, issues no request and no write, and drives `fault=1` with `fault_cause=01` for one cycle.
- Store lanes:
  - SB: `be = 1<<addr[1:0]`, `wdata = {4{data[7:0]}}`.
  - SH: `be = addr[1] ? 1100 : 0011`, `wdata = {2{data[15:0]}}`.
  - SW: `be = 1111`, `wdata = data`.
- Load byte enables use the same `be` rule as stores; `dmem_we=0`.
- Load extraction:
  - Byte at lane `addr[1:0]`, half at `addr[1]`.
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
- MEM exit on `dmem_ack`:
  - `dmem_req` drops the next cycle and the state returns to IDLE.
  - A load writes back on the cycle after ack.
  - A store produces no write.
- Timeout:
  - An 8-bit counter clears on entry to MEM and increments each MEM cycle without ack.
  - When it reaches `DMEM_TIMEOUT`, the access aborts: `dmem_req` drops, the state returns to IDLE, `fault=1` with `fault_cause=10`, and there is no write.
  - Ack in the same cycle the counter hits the limit counts as success.
- `rd==0`: `w_en` is never asserted. The memory access and any faults still occur.
- `dmem_ack` while in IDLE (stray) is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE. All outputs are 0 (`in_ready=1`, `dmem_req=0`, `w_en=0`, `w_sel=0`, `w_data=0`, `fault=0`, `fault_cause=00`), and the counter clears.
- Reset during MEM aborts the access with no writeback and no fault. An ack arriving after reset is ignored.
- ALU latency: transfer at cycle N gives `w_en` at N+1. Back-to-back ALU ops sustain 1 per cycle.
- Memory latency:
  - Transfer at N gives `dmem_req` high from N+1.
  - Ack at M gives `w_en` (loads) at M+1 and `in_ready=1` at M+1.
  - Minimum load-to-write is 2 cycles (ack at N+1).
- Misalignment fault: transfer at N gives `fault` at N+1. `in_ready` stays 1.
- Timeout fault: transfer at N with no ack gives `fault` and `dmem_req=0` at N+1+`DMEM_TIMEOUT`.
- `w_sel` and `w_data` hold their last values when `w_en=0`.

## Test plan
- Reset, then three back-to-back ALU ops (x1=0x11, x2=0x22, x3=0x33) -> `w_en` high on 3 consecutive cycles with matching `w_sel`/`w_data`; `in_ready` stays 1.
- LB from 0x1003 with `dmem_rdata`=0x80FF_0000, ack 3 cycles after request -> `dmem_addr`=0x1000, `be`=1000, `w_data`=0xFFFF_FF80 one cycle after ack. Same access as LBU -> 0x0000_0080.
- SH of 0x1234_ABCD to 0x2002 -> `be`=1100, `wdata`=0xABCD_ABCD, `we`=1, no `w_en`. LW from 0x2002 -> `fault_cause`=01, `dmem_req` never rises.
- Load with `DMEM_TIMEOUT`=4 and no ack -> `dmem_req` high exactly 4 cycles, `fault` pulse with cause 10, no `w_en`, `in_ready`=1 afterwards. Repeat with ack on the 4th cycle -> writeback, no fault.
- LW to x0 with ack -> bus cycle occurs, `w_en` stays 0. A stray ack while in IDLE -> no output change.
- Assert `rst` mid-MEM, then deliver ack one cycle after release -> all outputs 0 immediately, no writeback, no fault; the next ALU op writes normally.
